// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   scan_state_e  : per-slot FSM states (GAP = all-off gap, SHOW = digit lit)
//   SEG_0..SEG_F  : abcdefg patterns (bit 6 = a, bit 0 = g), 1 = segment lit
//   an_on/an_off  : anode drive level for a lit / dark digit given its polarity
package seg_scan_driver_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    function automatic logic an_on(input logic act_low);
        return ~act_low;
    endfunction

    function automatic logic an_off(input logic act_low);
        return act_low;
    endfunction

endpackage

// File: rtl/seg_scan_driver_seg7.sv
// seg7_hex_decode: pure combinational hex nibble to abcdefg decoder.
//   nib : 4-bit hex value
//   seg : {a,b,c,d,e,f,g}, active-high
module seg7_hex_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a DIGITS-wide 7-segment bank.
//   clk, rst           : clock / async active-low reset
//   load_valid/ready   : word handshake; load_ready = no word pending
//   load_data, load_dp : nibble k and dp bit k belong to digit k (0 = rightmost)
//   blank_lz           : live leading-zero suppression enable
//   a..g, dp           : registered segment / decimal point outputs, active-high
//   an                 : registered digit enables, polarity from AN_ACT_LOW
//   frame_tick         : high during the last SHOW cycle of the last digit
// A loaded word waits in a shadow register and is copied into the displayed
// (active) register only on the frame boundary edge, so a frame never mixes words.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 1000,
    parameter int BLANK_GAP  = 2,
    parameter int AN_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [DIGITS-1:0]     load_dp,
    input  logic                  blank_lz,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic                  e,
    output logic                  f,
    output logic                  g,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int CNT_MAX = (PRESCALE > BLANK_GAP) ? PRESCALE : BLANK_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GAP_LAST  = (BLANK_GAP > 0) ? CW'(BLANK_GAP - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    // With no gap the slot restarts directly in SHOW.
    localparam scan_state_e   SLOT_START = (BLANK_GAP > 0) ? GAP : SHOW;
    localparam logic          ACT_LOW    = (AN_ACT_LOW != 0);

    scan_state_e            state, state_nx;
    logic [IW-1:0]          idx, idx_nx;
    logic [CW-1:0]          cnt, cnt_nx;

    logic [DIGITS-1:0][3:0] shadow, active;
    logic [DIGITS-1:0]      shadow_dp, active_dp;
    logic                   pending;

    logic [DIGITS-1:0][6:0] dec_seg;
    logic [DIGITS-1:0]      blank;
    logic                   keep;
    logic                   lit;

    logic [DIGITS-1:0]      an_d, an_q;
    logic [6:0]             seg_d, seg_q;
    logic                   dp_d, dp_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SLOT_START;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt + CW'(1);
        case (state)
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nx = SHOW;
                    cnt_nx   = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nx = SLOT_START;
                    cnt_nx   = '0;
                    idx_nx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                end
            end
            default: begin
                state_nx = SLOT_START;
                cnt_nx   = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        // Gated with rst so the pulse is low while reset is held, even for
        // single-cycle-frame parameter sets.
        frame_tick = rst && (state == SHOW) && (cnt == SHOW_LAST) && (idx == IDX_LAST);
        lit        = (state == SHOW) && !blank[idx];
        an_d       = {DIGITS{an_off(ACT_LOW)}};
        seg_d      = '0;
        dp_d       = 1'b0;
        if (lit) begin
            an_d[idx] = an_on(ACT_LOW);
            seg_d     = dec_seg[idx];
            dp_d      = active_dp[idx];
        end
    end

    // ---------------- load handshake / frame-synchronous update ----------------
    assign load_ready = ~pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow    <= '0;
            shadow_dp <= '0;
            active    <= '0;
            active_dp <= '0;
            pending   <= 1'b0;
        end else if (frame_tick && pending) begin
            active    <= shadow;
            active_dp <= shadow_dp;
            pending   <= 1'b0;
        end else if (load_valid && load_ready) begin
            shadow    <= load_data;
            shadow_dp <= load_dp;
            pending   <= 1'b1;
        end
    end

    // ---------------- leading-zero mask ----------------
    // Walk from the top digit down; once a nonzero nibble or a lit dp is seen,
    // that digit and everything below it stays visible. Digit 0 never blanks.
    always_comb begin
        blank = '0;
        keep  = ~blank_lz;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            keep     = keep | (|active[k]) | active_dp[k];
            blank[k] = ~keep;
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
        seg7_hex_decode u_dec (
            .nib (active[gi]),
            .seg (dec_seg[gi])
        );
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= {DIGITS{an_off(ACT_LOW)}};
            seg_q <= '0;
            dp_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign dp = dp_q;
    assign an = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int DIGITS    = 4;
    localparam int PRESCALE  = 4;
    localparam int BLANK_GAP = 1;
    localparam int SLOT      = BLANK_GAP + PRESCALE;
    localparam int FRAME     = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  load_dp = '0;
    logic        blank_lz = 1'b0;
    logic        load_ready, a, b, c, d, e, f, g, dp, frame_tick;
    logic [3:0]  an;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;

    assign seg = {a, b, c, d, e, f, g};

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_GAP(BLANK_GAP), .AN_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_dp(load_dp), .blank_lz(blank_lz),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The scan position is plain arithmetic on the cycle count since reset
    // release; expected pins are the lit/blank decision of the previous cycle.
    logic [6:0]  dec_tab [16];
    int          mt;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_adp, m_sdp;
    bit          m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    function automatic bit lz_blank(input int k, input logic [15:0] w, input logic [3:0] dv,
                                    input logic blz);
        return blz && (k >= 1) && ((w >> (4 * k)) == 16'h0) && ((dv >> k) == 4'h0);
    endfunction

    always @(posedge clk or negedge rst) begin : model
        int p, dg;
        if (!rst) begin
            mt = 0; m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0; m_pend = 0;
            e_an = 4'hF; e_seg = '0; e_dp = 1'b0;
        end else begin
            p  = mt % FRAME;
            dg = p / SLOT;
            if ((p % SLOT) >= BLANK_GAP && !lz_blank(dg, m_act, m_adp, blank_lz)) begin
                e_an  = ~(4'b0001 << dg);
                e_seg = dec_tab[m_act[4*dg +: 4]];
                e_dp  = m_adp[dg];
            end else begin
                e_an = 4'hF; e_seg = '0; e_dp = 1'b0;
            end
            if (p == FRAME - 1 && m_pend) begin
                m_act = m_sh; m_adp = m_sdp; m_pend = 0;
            end else if (load_valid && !m_pend) begin
                m_sh = load_data; m_sdp = load_dp; m_pend = 1;
            end
            mt++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_seg", 32'(seg), 32'h0);
            chk("rst_dp", 32'(dp), 32'h0);
            chk("rst_ready", 32'(load_ready), 32'h1);
            chk("rst_tick", 32'(frame_tick), 32'h0);
        end else begin
            chk($sformatf("tick@%0d", mt), 32'(frame_tick), 32'((mt % FRAME) == FRAME - 1));
            chk($sformatf("ready@%0d", mt), 32'(load_ready), 32'(!m_pend));
            chk($sformatf("an@%0d", mt), 32'(an), 32'(e_an));
            chk($sformatf("seg@%0d", mt), 32'(seg), 32'(e_seg));
            chk($sformatf("dp@%0d", mt), 32'(dp), 32'(e_dp));
        end
    end

    // ---------------- helpers (called at negedge) ----------------
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 100);
        if (frame_tick !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_%s: got no frame_tick want frame_tick within 100 cycles", tag);
        end
    endtask

    task automatic wait_digit0(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== 4'b1110 && n < 100);
        chk({tag, "_an"}, 32'(an), 32'hE);
    endtask

    task automatic do_load(input logic [15:0] w, input logic [3:0] dv);
        int n;
        n = 0;
        load_data = w; load_dp = dv; load_valid = 1'b1;
        while (load_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (load_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL load_timeout: got ready=%b want ready=1", load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dpv;
        logic            blz;
        logic [3:0]      mask;   // digits expected to light up
        logic [3:0][6:0] seg;    // expected pattern per digit {d3,d2,d1,d0}
    } vec_t;

    vec_t vt [9];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0]      seen, cdp;
        logic [3:0][6:0] cseg;
        int              n;

        dec_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        vt[0] = '{16'h12AF, 4'b0000, 1'b0, 4'b1111, {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111}};
        vt[1] = '{16'h0050, 4'b0000, 1'b1, 4'b0011, {7'b0, 7'b0, 7'b1011011, 7'b1111110}};
        vt[2] = '{16'h0050, 4'b0100, 1'b1, 4'b0111, {7'b0, 7'b1111110, 7'b1011011, 7'b1111110}};
        vt[3] = '{16'h0000, 4'b0000, 1'b1, 4'b0001, {7'b0, 7'b0, 7'b0, 7'b1111110}};
        vt[4] = '{16'h0000, 4'b0000, 1'b0, 4'b1111, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
        vt[5] = '{16'h9E7D, 4'b0000, 1'b1, 4'b1111, {7'b1111011, 7'b1001111, 7'b1110000, 7'b0111101}};
        vt[6] = '{16'h0406, 4'b0001, 1'b1, 4'b0111, {7'b0, 7'b0110011, 7'b1111110, 7'b1011111}};
        vt[7] = '{16'h3B8C, 4'b1010, 1'b0, 4'b1111, {7'b1111001, 7'b0011111, 7'b1111111, 7'b1001110}};
        vt[8] = '{16'h00A0, 4'b1000, 1'b1, 4'b1111, {7'b1111110, 7'b1111110, 7'b1110111, 7'b1111110}};

        // reset hold, then release: one GAP cycle, first SHOW two cycles after release
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t1_gap_an", 32'(an), 32'hF);
        @(negedge clk);
        chk("t1_show_an", 32'(an), 32'hE);
        chk("t1_show_seg", 32'(seg), 32'b1111110);

        // frame period
        wait_tick("p0");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 100);
        chk("t2_period", 32'(n), 32'(FRAME));

        // table-driven display content
        for (int i = 0; i < 9; i++) begin
            blank_lz = vt[i].blz;
            do_load(vt[i].data, vt[i].dpv);
            wait_tick("v1");
            wait_tick("v2");
            seen = '0; cdp = '0; cseg = '0;
            repeat (FRAME) begin
                @(negedge clk);
                for (int k = 0; k < 4; k++)
                    if (an[k] == 1'b0) begin
                        seen[k] = 1'b1; cseg[k] = seg; cdp[k] = dp;
                    end
            end
            chk($sformatf("vec%0d_lit", i), 32'(seen), 32'(vt[i].mask));
            for (int k = 0; k < 4; k++)
                if (vt[i].mask[k]) begin
                    chk($sformatf("vec%0d_seg%0d", i, k), 32'(cseg[k]), 32'(vt[i].seg[k]));
                    chk($sformatf("vec%0d_dp%0d", i, k), 32'(cdp[k]), 32'(vt[i].dpv[k]));
                end
        end

        // second word offered while one is pending: held off until the boundary
        blank_lz = 1'b0;
        wait_tick("t4a");
        repeat (6) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        load_data = 16'h2222; load_dp = '0; load_valid = 1'b1;
        chk("t4_ready_busy", 32'(load_ready), 32'h0);
        wait_tick("t4b");
        chk("t4_ready_tick", 32'(load_ready), 32'h0);
        @(negedge clk);
        chk("t4_ready_after", 32'(load_ready), 32'h1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("t4_pending", 32'(load_ready), 32'h0);
        wait_digit0("t4_old");
        chk("t4_old_seg", 32'(seg), 32'b0110000);
        wait_tick("t4c");
        wait_digit0("t4_new");
        chk("t4_new_seg", 32'(seg), 32'b1101101);

        // load in the boundary cycle lands in shadow only
        wait_tick("t5a");
        load_data = 16'h0007; load_dp = '0; load_valid = 1'b1;
        chk("t5_ready_tick", 32'(load_ready), 32'h1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("t5_pending", 32'(load_ready), 32'h0);
        wait_digit0("t5_old");
        chk("t5_old_seg", 32'(seg), 32'b1101101);
        wait_tick("t5b");
        wait_digit0("t5_new");
        chk("t5_new_seg", 32'(seg), 32'b1110000);

        // async reset mid-SHOW with a word pending
        wait_tick("t6");
        @(negedge clk);
        do_load(16'h4444, 4'b1111);
        n = 0;
        while (an === 4'hF && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_mid_show", 32'(an != 4'hF), 32'h1);
        chk("t6_pending", 32'(load_ready), 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_an", 32'(an), 32'hF);
        chk("t6_async_seg", 32'(seg), 32'h0);
        chk("t6_async_dp", 32'(dp), 32'h0);
        chk("t6_async_ready", 32'(load_ready), 32'h1);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_gap_an", 32'(an), 32'hF);
        @(negedge clk);
        chk("t6_show_an", 32'(an), 32'hE);
        chk("t6_show_seg", 32'(seg), 32'b1111110);
        chk("t6_show_dp", 32'(dp), 32'h0);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) load_data = load_data >> (4 * $urandom_range(1, 4));
            load_dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if (i % 50 == 0) blank_lz = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        load_valid = 1'b0;
        repeat (45) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
